// File: rtl/fp_normalizer_pkg.sv
// Shared floating-point datapath definitions used by the alignment and normalisation stages.
package fp_defs;
    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/fp_normalizer_shift_reg_left.sv
// Loadable mantissa register with one-bit left and right shifts and a synchronous clear.
module shift_reg_left #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_l_i,
    input  logic             shift_r_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_val_i;
        end else if (shift_r_i) begin
            data_d = {1'b0, data_q[WIDTH-1:1]};
        end else if (shift_l_i) begin
            data_d = {data_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;
endmodule

// File: rtl/fp_normalizer.sv
// Post-add normaliser: one right shift on carry-out, otherwise left shifts (one per clock)
// until the hidden bit is set, with zero / underflow / overflow detection.
module fp_normalizer
    import fp_defs::*;
#(
    parameter int MANT_W = fp_defs::MANT_W,
    parameter int EXP_W  = fp_defs::EXP_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [MANT_W:0]   mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              busy,
    output logic              done,
    output logic [MANT_W-2:0] mant_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic              zero,
    output logic              underflow,
    output logic              overflow
);
    // Exponent is kept one bit wider so increments and decrements never wrap.
    localparam logic [EXP_W:0]  E_ONE   = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0]  E_ALL   = {1'b0, {EXP_W{1'b1}}};
    localparam logic [MANT_W:0] M_INF   = {2'b01, {(MANT_W-1){1'b0}}};

    state_e            state_q, state_d;
    logic [MANT_W:0]   m_q;
    logic [EXP_W:0]    e_q, e_d, e_inc;
    logic              zero_q, zero_d;
    logic              uf_q, uf_d;
    logic              of_q, of_d;
    logic              m_load, m_shl, m_shr;
    logic [MANT_W:0]   m_load_val;
    logic              norm_fin;

    shift_reg_left #(
        .WIDTH (MANT_W + 1)
    ) u_mant (
        .clk        (clk),
        .clear      (clear),
        .load_i     (m_load),
        .load_val_i (m_load_val),
        .shift_l_i  (m_shl),
        .shift_r_i  (m_shr),
        .q_o        (m_q)
    );

    assign e_inc    = e_q + E_ONE;
    assign norm_fin = m_q[MANT_W] || (m_q == '0) || m_q[MANT_W-1] || (e_q <= E_ONE);

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = NORM;
            NORM:    if (norm_fin) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        mant_out  = m_q[MANT_W-2:0];
        exp_out   = e_q[EXP_W-1:0];
        zero      = zero_q;
        underflow = uf_q;
        overflow  = of_q;
    end

    // Datapath control; the check order below is the normalisation priority.
    always_comb begin
        m_load     = 1'b0;
        m_load_val = '0;
        m_shl      = 1'b0;
        m_shr      = 1'b0;
        e_d        = e_q;
        zero_d     = zero_q;
        uf_d       = uf_q;
        of_d       = of_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_load     = 1'b1;
                    m_load_val = mant_in;
                    e_d        = {1'b0, exp_in};
                    zero_d     = 1'b0;
                    uf_d       = 1'b0;
                    of_d       = 1'b0;
                end
            end
            NORM: begin
                if (m_q[MANT_W]) begin
                    if (e_inc >= E_ALL) begin
                        of_d       = 1'b1;
                        e_d        = E_ALL;
                        m_load     = 1'b1;
                        m_load_val = M_INF;
                    end else begin
                        e_d   = e_inc;
                        m_shr = 1'b1;
                    end
                end else if (m_q == '0) begin
                    zero_d = 1'b1;
                    e_d    = '0;
                end else if (m_q[MANT_W-1]) begin
                    e_d = e_q;
                end else if (e_q <= E_ONE) begin
                    uf_d = 1'b1;
                    e_d  = '0;
                end else begin
                    m_shl = 1'b1;
                    e_d   = e_q - E_ONE;
                end
            end
            default: begin
                e_d = e_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            e_q    <= '0;
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
            of_q   <= 1'b0;
        end else begin
            e_q    <= e_d;
            zero_q <= zero_d;
            uf_q   <= uf_d;
            of_q   <= of_d;
        end
    end
endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: directed vectors push expectations, a monitor checks on done.
module tb_fp_normalizer;
    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic [24:0] mant_in;
    logic [7:0]  exp_in;
    logic        busy, done, zero, underflow, overflow;
    logic [22:0] mant_out;
    logic [7:0]  exp_out;

    typedef struct {
        logic [22:0] mant;
        logic [7:0]  expo;
        logic        z;
        logic        u;
        logic        o;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_e;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    fp_normalizer dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .mant_in   (mant_in),
        .exp_in    (exp_in),
        .busy      (busy),
        .done      (done),
        .mant_out  (mant_out),
        .exp_out   (exp_out),
        .zero      (zero),
        .underflow (underflow),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done actual=1 required=0 at cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                last_e = e;
                $display("txn %s: mant_out=%h exp_out=%h z=%b u=%b o=%b cyc=%0d",
                         e.name, mant_out, exp_out, zero, underflow, overflow, cyc);
                chk({e.name, "_mant"}, 32'(mant_out), 32'(e.mant));
                chk({e.name, "_exp"}, 32'(exp_out), 32'(e.expo));
                chk({e.name, "_zero"}, 32'(zero), 32'(e.z));
                chk({e.name, "_uf"}, 32'(underflow), 32'(e.u));
                chk({e.name, "_of"}, 32'(overflow), 32'(e.o));
                chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic run_case(input string name, input logic [24:0] m, input logic [7:0] ex,
                            input int k, input logic [22:0] em, input logic [7:0] ee,
                            input logic z, input logic u, input logic o, input bit poke);
        exp_t e;
        int   n;
        @(negedge clk);
        mant_in = m;
        exp_in  = ex;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        e.mant = em; e.expo = ee; e.z = z; e.u = u; e.o = o;
        e.cyc  = cyc + k + 1;
        e.name = name;
        sb_q.push_back(e);
        chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
        if (poke) begin
            mant_in = 25'h1000000;
            exp_in  = 8'hFE;
            start   = 1'b1;
            @(negedge clk);
            start   = 1'b0;
        end
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
        chk({name, "_busy_idle"}, 32'(busy), 32'd0);
        chk({name, "_hold_mant"}, 32'(mant_out), 32'(em));
        chk({name, "_hold_exp"}, 32'(exp_out), 32'(ee));
    endtask

    initial begin
        clear   = 1'b1;
        start   = 1'b0;
        mant_in = '0;
        exp_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mant", 32'(mant_out), 32'd0);
        chk("rst_exp", 32'(exp_out), 32'd0);
        chk("rst_flags", 32'({zero, underflow, overflow}), 32'd0);
        clear = 1'b0;

        run_case("normed",    25'h0800000, 8'h80, 0,  23'h000000, 8'h80, 0, 0, 0, 0);
        run_case("carry",     25'h1000001, 8'h80, 0,  23'h000000, 8'h81, 0, 0, 0, 0);
        run_case("carry_fr",  25'h1FFFFFF, 8'h10, 0,  23'h7FFFFF, 8'h11, 0, 0, 0, 0);
        run_case("max_shift", 25'h0000001, 8'h80, 23, 23'h000000, 8'h69, 0, 0, 0, 1);
        run_case("zero",      25'h0000000, 8'h55, 0,  23'h000000, 8'h00, 1, 0, 0, 0);
        run_case("underflow", 25'h0000010, 8'h03, 2,  23'h000040, 8'h00, 0, 1, 0, 0);
        run_case("uf_one",    25'h0000003, 8'h02, 1,  23'h000006, 8'h00, 0, 1, 0, 0);
        run_case("overflow",  25'h1000000, 8'hFE, 0,  23'h000000, 8'hFF, 0, 0, 1, 0);
        run_case("one_shift", 25'h0400000, 8'h10, 1,  23'h000000, 8'h0F, 0, 0, 0, 0);

        // Abort mid-shift: no expectation is queued, so any done pulse is flagged by the monitor.
        @(negedge clk);
        mant_in = 25'h0000001;
        exp_in  = 8'h80;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        repeat (5) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mant", 32'(mant_out), 32'd0);
        chk("abort_exp", 32'(exp_out), 32'd0);
        chk("abort_flags", 32'({zero, underflow, overflow}), 32'd0);
        repeat (30) @(negedge clk);
        run_case("post_abort", 25'h0200000, 8'h40, 2, 23'h000000, 8'h3E, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
